// File: rtl/dehaze_pkg.sv
// Shared constants, state encoding and tag bundle for the pixel transmitter.
package dehaze_pkg;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int FRAME_PIX_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int PIX_W_DEF     = 24;
    localparam int ADDR_W        = 19;
    localparam int CNT_W         = 16;
    localparam int TAG_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

endpackage

// File: rtl/pix_tag_fifo.sv
// Four-entry FIFO carrying a pixel word plus its frame tags.
module pix_tag_fifo #(
    parameter int DW = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          not_empty,
    output logic [2:0]    count
);

    logic [DW-1:0] mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count != 3'd4) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            // push and pop together leave the count alone
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign not_empty = (count != 3'd0);

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame-buffer to valid/ready pixel stream with sof/eol/eof tags.
// Define PIX_TX_TEST_PATTERN_EN to replace memory reads by an x/y pattern.
module pixel_stream_tx
    import dehaze_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int PIX_W    = PIX_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  picture_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int WORD_W    = PIX_W + TAG_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0]  LAST_X    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  LAST_Y    = CNT_W'(V_ACTIVE - 1);

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic               rd_go;
    logic               rd_pend;
    logic               last_rd;
    logic               xfer;
    pix_tag_t           tag_now;
    pix_tag_t           tag_pend;
    pix_tag_t           head_tag;
    logic [PIX_W-1:0]   push_pix;
    logic [WORD_W-1:0]  head_data;
    logic [2:0]         fifo_count;

    // throttle so the FIFO can absorb every read still in flight
    assign rd_go   = (state == ST_FETCH)
                  && ((fifo_count + {2'b00, rd_pend}) <= 3'd2);
    assign last_rd = rd_go && (mem_addr == LAST_ADDR);
    assign xfer    = pix_valid && pix_ready;

    assign tag_now.sof = (x == '0) && (y == '0);
    assign tag_now.eol = (x == LAST_X);
    assign tag_now.eof = (x == LAST_X) && (y == LAST_Y);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start)                 state_nxt = ST_FETCH;
            ST_FETCH: if (last_rd)               state_nxt = ST_DRAIN;
            ST_DRAIN: if (xfer && head_tag.eof) state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            x        <= '0;
            y        <= '0;
            rd_pend  <= 1'b0;
            tag_pend <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_go;
            if (rd_go) begin
                tag_pend <= tag_now;
                mem_addr <= last_rd ? '0 : mem_addr + ADDR_W'(1);
                if (x == LAST_X) begin
                    x <= '0;
                    y <= (y == LAST_Y) ? '0 : y + CNT_W'(1);
                end else begin
                    x <= x + CNT_W'(1);
                end
            end
        end
    end

`ifdef PIX_TX_TEST_PATTERN_EN
    logic [PIX_W-1:0] pat_pend;
    logic             unused_rd;

    assign unused_rd = ^mem_rd_data;
    assign mem_rd_en = 1'b0;
    assign push_pix  = pat_pend;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_pend <= '0;
        end else if (rd_go) begin
            pat_pend <= PIX_W'({x[7:0], y[7:0], x[7:0] ^ y[7:0]});
        end
    end
`else
    assign mem_rd_en = rd_go;
    assign push_pix  = mem_rd_data;
`endif

    pix_tag_fifo #(
        .DW (WORD_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (rd_pend),
        .push_data ({push_pix, tag_pend}),
        .pop       (pix_ready),
        .head_data (head_data),
        .not_empty (pix_valid),
        .count     (fifo_count)
    );

    assign head_tag     = pix_tag_t'(head_data[TAG_W-1:0]);
    assign picture_data = head_data[WORD_W-1:TAG_W];
    assign sof          = pix_valid && head_tag.sof;
    assign eol          = pix_valid && head_tag.eol;
    assign eof          = pix_valid && head_tag.eof;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx on a small 8x4 frame.
module tb_pixel_stream_tx;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int F  = H * V;
    localparam int PW = 24;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          start     = 1'b0;
    logic          pix_ready = 1'b0;
    logic          mem_rd_en;
    logic [18:0]   mem_addr;
    logic [PW-1:0] mem_rd_data = '0;
    logic [PW-1:0] picture_data;
    logic          pix_valid;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int reads  = 0;
    int frames = 0;
    int cyc    = 0;
    int sof_cyc = 0;
    int eof_cyc = 0;
    bit armed  = 1'b0;
    bit pstall = 1'b0;
    logic [PW+2:0] pword = '0;

    pixel_stream_tx #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .PIX_W    (PW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .picture_data (picture_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .sof          (sof),
        .eol          (eol),
        .eof          (eof),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [PW-1:0] mem_val(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E3779B1 + 32'h0000_1234;
        return h[31:8];
    endfunction

    function automatic logic [PW-1:0] exp_pix(input int idx);
`ifdef PIX_TX_TEST_PATTERN_EN
        logic [7:0] ex;
        logic [7:0] ey;
        ex = 8'(idx % H);
        ey = 8'(idx / H);
        return {ex, ey, ex ^ ey};
`else
        return mem_val(idx);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory answers exactly one cycle after the strobe, garbage otherwise
    always @(posedge sys_clk) begin
        if (mem_rd_en)
            mem_rd_data <= mem_val(int'(mem_addr));
        else
            mem_rd_data <= PW'($urandom);
    end

    // reference model: frame position k, reads issued, stall stability
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            k      = 0;
            reads  = 0;
            pstall = 1'b0;
            armed  = 1'b0;
        end else begin
            cyc++;
`ifdef PIX_TX_TEST_PATTERN_EN
            chk("rd_en_pattern", mem_rd_en, 0);
`else
            if (mem_rd_en) begin
                chk("rd_armed", armed, 1);
                chk("rd_addr", mem_addr, reads);
                chk("rd_outstanding_le2", (reads - k) <= 2, 1);
                chk("rd_in_frame", reads < F, 1);
                reads++;
            end
`endif
            if (pstall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_word", {picture_data, sof, eol, eof}, pword);
            end
            pstall = pix_valid && !pix_ready;
            pword  = {picture_data, sof, eol, eof};
            if (pix_valid && pix_ready) begin
                chk("pix_data", picture_data, exp_pix(k));
                chk("sof", sof, k == 0);
                chk("eol", eol, (k % H) == H - 1);
                chk("eof", eof, k == F - 1);
`ifdef PIX_TX_TEST_PATTERN_EN
                if (k == 5 + 3 * H)
                    chk("pattern_x5_y3", picture_data, 24'h050306);
`else
                chk("xfer_after_read", k < reads, 1);
`endif
                if (k == 0) sof_cyc = cyc;
                if (k == F - 1) begin
                    eof_cyc = cyc;
                    k       = 0;
                    reads   = 0;
                    armed   = 1'b0;
                    frames++;
                end else begin
                    k++;
                end
            end
        end
    end

    typedef struct {
        logic        rd;
        logic [18:0] addr;
        logic        valid;
        logic        sof;
        logic        busy;
    } lat_t;

    lat_t tab[5];

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_data"}, picture_data, 0);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_sof"}, sof, 0);
        chk({tag, "_eol"}, eol, 0);
        chk({tag, "_eof"}, eof, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_frame(input bit rand_ready, input bit mid_start);
        int target;
        int n;
        target = frames + 1;
        n      = 0;
        @(posedge sys_clk); #1;
        start = 1'b1;
        armed = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        while (frames < target && n < 5000) begin
            pix_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            start     = mid_start && (n == 7);
            @(posedge sys_clk); #1;
            n++;
        end
        start = 1'b0;
        chk("frame_done", frames >= target, 1);
        chk("busy_after_eof", busy, 0);
    endtask

    logic rd_flag;

    initial begin
        rd_flag = 1'b1;
`ifdef PIX_TX_TEST_PATTERN_EN
        rd_flag = 1'b0;
`endif
        tab[0] = '{1'b0,    19'd0, 1'b0, 1'b0, 1'b0};
        tab[1] = '{rd_flag, 19'd0, 1'b0, 1'b0, 1'b1};
        tab[2] = '{rd_flag, 19'd1, 1'b0, 1'b0, 1'b1};
        tab[3] = '{rd_flag, 19'd2, 1'b1, 1'b1, 1'b1};
        tab[4] = '{rd_flag, 19'd3, 1'b1, 1'b0, 1'b1};

        #2 sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs_zero("reset");
        sys_rst_n = 1'b1;
        pix_ready = 1'b1;
        repeat (4) @(posedge sys_clk);

        // start latency and first pixels, ready held high
        #1;
        start = 1'b1;
        armed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("lat_rd_en", mem_rd_en, tab[i].rd);
            if (tab[i].rd)
                chk("lat_addr", mem_addr, tab[i].addr);
            chk("lat_valid", pix_valid, tab[i].valid);
            chk("lat_sof", sof, tab[i].sof);
            chk("lat_busy", busy, tab[i].busy);
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        for (int n = 0; n < 5000 && frames < 1; n++)
            @(posedge sys_clk);
        #1;
        chk("frame1_done", frames, 1);
        chk("frame1_busy_low", busy, 0);
        chk("frame1_span", eof_cyc - sof_cyc + 1, F);

        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("idle_no_rd", mem_rd_en, 0);
        end

        run_frame(1'b1, 1'b0);
        run_frame(1'b1, 1'b1);
        run_frame(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            chk("no_queued_restart", busy, 0);
        end

        // abort mid-frame with an asynchronous reset
        @(posedge sys_clk); #1;
        start = 1'b1;
        armed = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int n = 0; n < 2000 && k < 10; n++) begin
            pix_ready = 1'($urandom % 2);
            @(posedge sys_clk); #1;
        end
        chk("reached_pixel_10", k >= 10, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("post_reset_no_rd", mem_rd_en, 0);
        end
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
